pps_capture_iomem: RTL and testbench
====================================

Name: pps_capture_iomem

Overview:
- Responder (slave) on the SoC iomem bus. Timestamps rising edges of the GPS PPS input against a free-running 32-bit system-clock counter.
- Buffers the timestamps in a small FIFO that firmware drains over iomem.
- Raises a level interrupt, intended for one of irq_5..irq_7, while captures are pending.
- Sits in the iomem window at and above 0x0200_0000, beside the UART and SPI flash config registers.

Parameters:
- BASE_ADDR, 32'h0300_0000: base of the 256-byte register window; bits [7:0] are ignored.
- FIFO_DEPTH, 8: timestamp FIFO entries; must be a power of two, 2..64.
- SYNC_STAGES, 2: PPS synchronizer flops; must be at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iomem_valid  in  1  request valid; held by initiator until ready
- iomem_ready  out  1  request complete
- iomem_wstrb  in  4  byte write strobes; 0 means read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid when iomem_ready=1
- pps_in  in  1  asynchronous PPS pin
- irq  out  1  level interrupt

Behaviour:
- Reset (synchronous, active-high):
  - iomem_ready=0, iomem_rdata=0, irq=0.
  - Counter=0, FIFO empty, CTRL=0, overflow=0, synchronizer flops=0.
  - Reset asserted mid-transaction aborts it: no ready is issued, and any FIFO pop is discarded.
- Select: sel = iomem_valid && iomem_addr[31:8]==BASE_ADDR[31:8].
- Handshake:
  - iomem_ready <= sel && !iomem_ready, so ready is exactly one cycle and latency is 1 cycle after valid is first seen.
  - Back-to-back requests therefore complete every second cycle.
  - Side effects (register writes, FIFO pop) happen only in the cycle where ready is registered, so exactly once per transaction.
  - iomem_rdata is registered together with ready. It is 0 whenever ready=0.
- Register map (offset = addr[7:2]*4):
  - 0x00 CTRL, RW.
    - bit0 EN: capture enable.
    - bit1 IRQ_EN.
    - bit2 FLUSH: write-1 pulse that empties the FIFO; reads as 0.
    - Updated only when wstrb[0]=1.
  - 0x04 STATUS, RO except bit2.
    - bit0 NONEMPTY.
    - bit1 FULL.
    - bit2 OVF: sticky; write 1 with wstrb[0] to clear.
    - [14:8] LEVEL: FIFO entry count.
  - 0x08 COUNT, RO: live counter value, sampled in the ready cycle.
  - 0x0C DATA, RO.
    - A read with wstrb=0 returns the FIFO head and pops it.
    - A read when empty returns 0 and leaves state unchanged.
    - Writes are ignored.
  - Other offsets: read 0, writes ignored; ready is still issued.
- Counter:
  - 32-bit, increments every clk regardless of EN.
  - Wraps 0xFFFF_FFFF -> 0 with no flag.
- Capture path:
  - pps_in passes through SYNC_STAGES flops, then an edge-detect flop.
  - rise = sync_out && !prev.
  - On rise with EN=1, the counter value of that same cycle is pushed to the FIFO.
  - Pin-to-rise latency is SYNC_STAGES+1 cycles.
  - With EN=0, edges are ignored; the edge detector still tracks the pin, so enabling while the pin is high does not capture.
- FIFO boundary conditions:
  - Push while full: data dropped, OVF set, contents untouched.
  - Push and pop in the same cycle, not full: both occur, LEVEL unchanged, popped value is the old head.
  - Push and pop in the same cycle while empty: the pop returns 0, and the push lands as the only entry.
  - Push and pop in the same cycle while full: the pop occurs and the push is accepted, with no overflow.
  - FLUSH in the same cycle as a push: the FIFO ends empty (flush wins).
  - FLUSH does not clear OVF.
- irq = IRQ_EN && (NONEMPTY || OVF). It is registered, updating 1 cycle after the state change.

Decomposition:
- Package pps_capture_pkg:
  - Register offsets: REG_CTRL, REG_STATUS, REG_COUNT, REG_DATA.
  - CTRL bit indices: EN, IRQ_EN, FLUSH.
  - STATUS bit indices: NONEMPTY, FULL, OVF, LEVEL_LSB.
- Sub-module pps_capture_fifo:
  - Synchronous FIFO, width 32, depth FIFO_DEPTH.
  - Ports: push, pop, flush, full, empty, level.
  - Implements the simultaneous push/pop rules above.
  - Top level holds the counter, synchronizer, bus decode and registers.

Test Plan:
1. Reset, then read STATUS at BASE+0x04 -> rdata=0, ready high exactly 1 cycle, 1 cycle after valid; irq=0.
2. Write CTRL=0x3, pulse pps_in high at counter N -> DATA read returns N+3 (SYNC_STAGES=2); irq rises, then falls 1 cycle after the pop empties the FIFO; second DATA read returns 0.
3. EN=1, apply 10 PPS edges without reading -> STATUS LEVEL=8, FULL=1, OVF=1; DATA reads return the first 8 timestamps in order; write STATUS=0x4 -> OVF=0, irq=0.
4. DATA pop at LEVEL=3 timed with a rise in the same cycle -> returned value is the oldest entry, LEVEL stays 3, the new timestamp becomes the last entry.
5. Force the counter near wrap (reset, wait 2^32-2 cycles, or a bench backdoor to 0xFFFF_FFFE), capture 3 cycles later -> timestamp 0x0000_0001; COUNT reads continue from 0.
6. Assert reset during an outstanding DATA read with LEVEL=2 -> no ready, FIFO empty, CTRL=0 after reset; access to BASE+0x10 -> ready with rdata=0; access at BASE_ADDR+0x100 -> no ready.

Source files
------------

// File: rtl/pps_capture_pkg.sv
// pps_capture_pkg
//   Shared definitions for the PPS timestamp capture block: register word
//   offsets within the iomem window, CTRL/STATUS bit positions and a helper
//   that packs the STATUS word.
package pps_capture_pkg;

  // Register word indices (byte offset = index * 4).
  localparam logic [5:0] REG_CTRL   = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_COUNT  = 6'h02;
  localparam logic [5:0] REG_DATA   = 6'h03;

  // CTRL bits.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  // STATUS bits.
  localparam int STAT_NONEMPTY  = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_W   = 7;

  function automatic logic [31:0] status_word(input logic nonempty,
                                              input logic full,
                                              input logic ovf,
                                              input logic [STAT_LEVEL_W-1:0] level);
    logic [31:0] w;
    w = '0;
    w[STAT_NONEMPTY] = nonempty;
    w[STAT_FULL]     = full;
    w[STAT_OVF]      = ovf;
    w[STAT_LEVEL_LSB +: STAT_LEVEL_W] = level;
    return w;
  endfunction

endpackage

// File: rtl/pps_capture_fifo.sv
// pps_capture_fifo
//   Synchronous timestamp FIFO.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     i_push, i_data  : write request and data
//     i_pop           : read request; o_head is the entry being popped
//     i_flush         : empties the FIFO, wins over a same-cycle push
//     o_head          : current head entry (undefined when empty)
//     o_full, o_empty : occupancy flags
//     o_level         : entry count
//     o_drop          : a push was rejected because the FIFO was full
//   A pop on an empty FIFO does nothing; a pop frees room for a same-cycle
//   push even when full.
module pps_capture_fifo
  import pps_capture_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level,
  output logic             o_drop
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == LW'(DEPTH));
  assign o_level   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_drop    = i_push && o_full && !w_do_pop;

  // When full, the write slot equals the head slot; the head has already
  // been read combinationally this cycle, so overwriting it is safe.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pps_capture_iomem.sv
// pps_capture_iomem
//   iomem responder that timestamps rising edges of the GPS PPS pin against
//   a free-running 32-bit counter and queues them for firmware.
//   Ports:
//     clk, reset   : system clock, synchronous active-high reset
//     iomem_valid  : request valid, held by the initiator until ready
//     iomem_ready  : one-cycle completion pulse
//     iomem_wstrb  : byte write strobes, 0 = read
//     iomem_addr   : byte address; window is BASE_ADDR[31:8], bits [7:2] pick
//                    CTRL(0x00) STATUS(0x04) COUNT(0x08) DATA(0x0C)
//     iomem_wdata  : write data
//     iomem_rdata  : read data, zero except in the ready cycle
//     pps_in       : asynchronous PPS pin
//   Handshake: a selected request is accepted on the first clock where ready
//     is low; ready and rdata are registered at that edge, and every side
//     effect (register write, FIFO pop) happens at that same edge only, so
//     each transaction acts exactly once.
//     irq         : level interrupt, IRQ_EN && (FIFO nonempty || OVF)
module pps_capture_iomem
  import pps_capture_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        pps_in,
  output logic        irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]            r_count;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  logic                   r_prev;
  logic                   r_en;
  logic                   r_irq_en;
  logic                   r_ovf;
  logic                   r_ready;
  logic [31:0]            r_rdata;
  logic                   r_irq;

  logic        w_sel;
  logic        w_fire;
  logic [5:0]  w_idx;
  logic        w_is_read;
  logic        w_rise;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic        w_ctrl_wr;
  logic        w_ovf_clr;
  logic [31:0] w_head;
  logic        w_full;
  logic        w_empty;
  logic [LW-1:0] w_level;
  logic        w_drop;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_sel     = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign w_fire    = w_sel && !r_ready;
  assign w_idx     = iomem_addr[7:2];
  assign w_is_read = (iomem_wstrb == 4'b0000);

  assign w_ctrl_wr = w_fire && (w_idx == REG_CTRL) && iomem_wstrb[0];
  assign w_flush   = w_ctrl_wr && iomem_wdata[CTRL_FLUSH];
  assign w_ovf_clr = w_fire && (w_idx == REG_STATUS) && iomem_wstrb[0]
                     && iomem_wdata[STAT_OVF];
  assign w_pop     = w_fire && (w_idx == REG_DATA) && w_is_read;

  // The synchronizer output feeds a dedicated edge flop, so the pin-to-rise
  // latency is SYNC_STAGES+1 cycles. The edge flops track the pin even while
  // capture is disabled, so enabling with the pin already high is not a rise.
  assign w_rise = r_edge && !r_prev;
  assign w_push = w_rise && r_en;

  assign w_unused = &{1'b0, iomem_wdata[31:3], iomem_wstrb[3:1], iomem_addr[1:0]};

  pps_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (r_count),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_sync  <= '0;
      r_edge  <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_count <= r_count + 32'd1;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], pps_in};
      r_edge  <= r_sync[SYNC_STAGES-1];
      r_prev  <= r_edge;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_CTRL: begin
        w_rdata[CTRL_EN]     = r_en;
        w_rdata[CTRL_IRQ_EN] = r_irq_en;
      end
      REG_STATUS: w_rdata = status_word(!w_empty, w_full, r_ovf,
                                        STAT_LEVEL_W'(w_level));
      REG_COUNT:  w_rdata = r_count;
      REG_DATA: begin
        if (w_is_read && !w_empty) begin
          w_rdata = w_head;
        end
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_ready <= w_fire;
      r_rdata <= w_fire ? w_rdata : 32'd0;
      if (w_ctrl_wr) begin
        r_en     <= iomem_wdata[CTRL_EN];
        r_irq_en <= iomem_wdata[CTRL_IRQ_EN];
      end
      // A capture lost in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
      r_irq <= r_irq_en && (!w_empty || r_ovf);
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_irq;

endmodule

// File: tb/tb_pps_capture_iomem.sv
module tb_pps_capture_iomem;

  localparam logic [31:0] BASE  = 32'h0300_0000;
  localparam int          DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        pps_in;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  // Scoreboard: expected read data, and whether that response is checked.
  logic [31:0] exp_q[$];
  logic        chk_q[$];

  // Behavioural model state.
  logic [31:0] m_count = '0;
  logic [31:0] m_q[$];
  logic [31:0] sched_q[$];
  logic m_en = 0, m_irq_en = 0, m_ovf = 0, m_ready = 0, m_irq = 0, m_pin_prev = 0;

  pps_capture_iomem #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .pps_in      (pps_in),
    .irq         (irq)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Works in terms of the counter value: a pin level first seen high at a
  // clock edge where the counter reads N produces a capture of N+3, which
  // lands at the edge where the counter reads N+3 (if EN is set then).
  always @(posedge clk) begin : model
    logic [31:0] pre;
    logic [31:0] resp;
    logic        fire;
    logic        en_pre;
    logic        do_flush;
    logic        irq_n;
    if (reset) begin
      m_count = '0;
      m_q.delete();
      sched_q.delete();
      m_en = 0; m_irq_en = 0; m_ovf = 0; m_ready = 0; m_irq = 0; m_pin_prev = 0;
    end else begin
      pre      = m_count;
      irq_n    = m_irq_en && ((m_q.size() != 0) || m_ovf);
      fire     = iomem_valid && (iomem_addr[31:8] == BASE[31:8]) && !m_ready;
      en_pre   = m_en;
      do_flush = 1'b0;
      if (fire) begin
        resp = '0;
        case (iomem_addr[7:2])
          6'd0: begin
            resp = {30'd0, m_irq_en, m_en};
            if (iomem_wstrb[0]) begin
              m_en     = iomem_wdata[0];
              m_irq_en = iomem_wdata[1];
              do_flush = iomem_wdata[2];
            end
          end
          6'd1: begin
            resp = {17'd0, 7'(m_q.size()), 5'd0, m_ovf,
                    (m_q.size() == DEPTH), (m_q.size() != 0)};
            if (iomem_wstrb[0] && iomem_wdata[2]) m_ovf = 1'b0;
          end
          6'd2: resp = pre;
          6'd3: if (iomem_wstrb == 4'd0 && m_q.size() != 0) resp = m_q.pop_front();
          default: resp = '0;
        endcase
        exp_q.push_back(resp);
        chk_q.push_back(iomem_wstrb == 4'd0);
      end
      if (sched_q.size() != 0 && sched_q[0] == pre) begin
        void'(sched_q.pop_front());
        if (en_pre) begin
          if (m_q.size() < DEPTH) m_q.push_back(pre);
          else m_ovf = 1'b1;
        end
      end
      if (do_flush) m_q.delete();
      m_ready = fire;
      m_irq   = irq_n;
      m_count = pre + 32'd1;
      if (pps_in && !m_pin_prev) sched_q.push_back(pre + 32'd3);
      m_pin_prev = pps_in;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    logic        c;
    if (mon_en) begin
      n_checks++;
      if (iomem_ready !== m_ready) begin
        n_errors++;
        $display("FAIL ready: got %b expected %b at %0t", iomem_ready, m_ready, $time);
      end
      n_checks++;
      if (irq !== m_irq) begin
        n_errors++;
        $display("FAIL irq: got %b expected %b at %0t", irq, m_irq, $time);
      end
      if (iomem_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ready: rdata %h with no pending request at %0t",
                   iomem_rdata, $time);
        end else begin
          e = exp_q.pop_front();
          c = chk_q.pop_front();
          if (c) begin
            n_checks++;
            if (iomem_rdata !== e) begin
              n_errors++;
              $display("FAIL rdata: got %h expected %h at %0t", iomem_rdata, e, $time);
            end
          end
        end
      end else begin
        n_checks++;
        if (iomem_rdata !== 32'd0) begin
          n_errors++;
          $display("FAIL rdata_idle: got %h expected 0 at %0t", iomem_rdata, $time);
        end
      end
    end
  end

  // ---------------- driver tasks (start and end on a negedge) ----------------
  task automatic bus_raw(input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wd);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wd;
    @(negedge clk);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
    @(negedge clk);
  endtask

  task automatic bus(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd);
    bus_raw({BASE[31:8], off}, strb, wd);
  endtask

  // Valid held for several cycles: back-to-back transactions.
  task automatic bus_hold(input logic [7:0] off, input int cycles);
    iomem_valid = 1'b1;
    iomem_addr  = {BASE[31:8], off};
    iomem_wstrb = 4'd0;
    repeat (cycles) @(negedge clk);
    iomem_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    pps_in = 1'b1;
    repeat (hi) @(negedge clk);
    pps_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
    iomem_addr  = '0;
    iomem_wdata = '0;
    pps_in = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset state: STATUS reads 0, irq low.
    bus(8'h04, 4'h0, 32'd0);
    bus(8'h00, 4'h0, 32'd0);
    bus(8'h08, 4'h0, 32'd0);

    // Single capture, pop, empty pop.
    bus(8'h00, 4'h1, 32'h3);
    pulse(2, 6);
    bus(8'h04, 4'h0, 32'd0);
    bus(8'h0C, 4'h0, 32'd0);
    idle(2);
    bus(8'h0C, 4'h0, 32'd0);

    // Overflow: ten edges, no reads.
    for (int i = 0; i < 10; i++) pulse($urandom_range(1, 4), $urandom_range(1, 5));
    idle(4);
    bus(8'h04, 4'h0, 32'd0);
    for (int i = 0; i < 9; i++) bus(8'h0C, 4'h0, 32'd0);
    bus(8'h04, 4'h1, 32'h4);
    idle(2);
    bus(8'h04, 4'h0, 32'd0);

    // Pop at LEVEL=3 coinciding with a capture landing.
    bus(8'h00, 4'h1, 32'h7);
    for (int i = 0; i < 3; i++) pulse(2, 3);
    idle(4);
    pps_in = 1'b1;
    idle(3);
    bus(8'h0C, 4'h0, 32'd0);
    pps_in = 1'b0;
    bus(8'h04, 4'h0, 32'd0);
    for (int i = 0; i < 3; i++) bus(8'h0C, 4'h0, 32'd0);

    // Full FIFO, pop together with a landing capture: no overflow.
    bus(8'h00, 4'h1, 32'h7);
    for (int i = 0; i < DEPTH; i++) pulse(2, 3);
    idle(4);
    pps_in = 1'b1;
    idle(3);
    bus(8'h0C, 4'h0, 32'd0);
    pps_in = 1'b0;
    bus(8'h04, 4'h0, 32'd0);

    // Flush in the same cycle a capture lands: FIFO ends empty.
    pps_in = 1'b1;
    idle(3);
    bus(8'h00, 4'h1, 32'h7);
    pps_in = 1'b0;
    bus(8'h04, 4'h0, 32'd0);

    // Randomized mix.
    bus(8'h00, 4'h1, 32'h3);
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 8))
        0, 1: pulse($urandom_range(1, 4), $urandom_range(1, 5));
        2:    bus(8'h0C, 4'h0, 32'd0);
        3:    bus(8'h04, 4'h0, 32'd0);
        4:    bus(8'h08, 4'h0, 32'd0);
        5:    bus(8'h00, 4'h1, {29'd0, 1'($urandom_range(0, 5) == 0), 1'b1,
                                1'($urandom_range(0, 4) != 0)});
        6:    bus_hold(8'h0C, $urandom_range(2, 5));
        7:    bus(8'h04, 4'h1, 32'h4);
        default: bus(8'(4 * $urandom_range(4, 63)), 4'($urandom_range(0, 15)), $urandom);
      endcase
    end
    bus(8'h00, 4'h1, 32'h3);

    // Counter wrap: capture from 0xFFFF_FFFE yields 0x0000_0001.
    idle(6);
    force dut.r_count = 32'hFFFF_FFFE;
    m_count = 32'hFFFF_FFFE;
    pps_in = 1'b1;
    #1 release dut.r_count;
    idle(2);
    bus(8'h08, 4'h0, 32'd0);
    pps_in = 1'b0;
    idle(3);
    bus(8'h0C, 4'h0, 32'd0);
    bus(8'h08, 4'h0, 32'd0);

    // Reset during an outstanding DATA read with LEVEL=2.
    bus(8'h00, 4'h1, 32'h7);
    pulse(2, 3);
    pulse(2, 3);
    idle(4);
    iomem_valid = 1'b1;
    iomem_addr  = {BASE[31:8], 8'h0C};
    iomem_wstrb = 4'd0;
    reset = 1'b1;
    @(negedge clk);
    iomem_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus(8'h00, 4'h0, 32'd0);
    bus(8'h04, 4'h0, 32'd0);
    bus(8'h10, 4'h0, 32'd0);
    bus_raw(BASE + 32'h100, 4'h0, 32'd0);
    idle(4);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
